// File: rtl/rob_tag_free_list_if.sv
// Tag free-list handshake bundle between dispatch/retire and the free list.
// Dispatch and retire drive the master side; the free list is the slave.
interface rob_tag_free_list_if #(
  parameter int TAG_W = 6
);
  logic             i_alloc_req;
  logic [TAG_W-1:0] o_alloc_tag;
  logic             o_alloc_valid;
  logic             i_retire_valid;
  logic [TAG_W-1:0] i_retire_tag;
  logic             i_flush;
  logic [TAG_W-1:0] o_count;
  logic             o_err;

  modport slave (
    input  i_alloc_req,
    input  i_retire_valid,
    input  i_retire_tag,
    input  i_flush,
    output o_alloc_tag,
    output o_alloc_valid,
    output o_count,
    output o_err
  );

  modport master (
    output i_alloc_req,
    output i_retire_valid,
    output i_retire_tag,
    output i_flush,
    input  o_alloc_tag,
    input  o_alloc_valid,
    input  o_count,
    input  o_err
  );
endinterface

// File: rtl/rob_tag_free_list.sv
// Circular free list of ROB tags 1..NUM_TAGS; a flush reclaims in-flight tags.
// Define ROB_TAG_FREE_CHECK_EN to track in-flight tags and flag illegal frees.
module rob_tag_free_list #(
  parameter int TAG_W    = 6,
  parameter int NUM_TAGS = 2**TAG_W - 1
) (
  input logic                 i_clk,
  input logic                 i_rst,
  rob_tag_free_list_if.slave  bus
);
  localparam int DEPTH = 2**TAG_W;

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [TAG_W-1:0] r_rd_ptr;
  logic [TAG_W-1:0] r_wr_ptr;

  logic [TAG_W-1:0] w_count;
  logic [TAG_W-1:0] w_head;
  logic [TAG_W-1:0] w_wr_next;
  logic             w_full;
  logic             w_empty;
  logic             w_free_ok;
  logic             w_alloc_ok;

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_count == TAG_W'(NUM_TAGS));
  assign w_empty  = (w_count == '0);
  assign w_head   = r_mem[r_rd_ptr];

  // A flush owns the cycle: no tag leaves the list while it is rebuilt.
  assign w_alloc_ok = bus.i_alloc_req && !w_empty && !bus.i_flush;
  assign w_wr_next  = w_free_ok ? r_wr_ptr + 1'b1 : r_wr_ptr;

  assign bus.o_alloc_tag   = w_head;
  assign bus.o_alloc_valid = !w_empty;
  assign bus.o_count       = w_count;

`ifdef ROB_TAG_FREE_CHECK_EN
  logic [DEPTH-1:0] r_inflight;
  logic [DEPTH-1:0] w_inflight_next;
  logic             r_err;
  logic             w_free_bad;

  // Only a tag that is really out in the ROB may come back.
  assign w_free_ok  = bus.i_retire_valid
                   && (bus.i_retire_tag != '0)
                   && !w_full
                   && r_inflight[bus.i_retire_tag];
  assign w_free_bad = bus.i_retire_valid && !w_free_ok;

  // Next in-flight set: flush empties it, else set popped and clear freed.
  always_comb begin
    w_inflight_next = r_inflight;
    if (bus.i_flush) begin
      w_inflight_next = '0;
    end else begin
      if (w_alloc_ok)
        w_inflight_next[w_head] = 1'b1;
      if (w_free_ok)
        w_inflight_next[bus.i_retire_tag] = 1'b0;
    end
  end

  // In-flight bitmap and sticky illegal-free flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_inflight_next;
      r_err      <= r_err | w_free_bad;
    end
  end

  assign bus.o_err = r_err;
`else
  // Unchecked: any non-zero tag is accepted while there is room.
  assign w_free_ok = bus.i_retire_valid
                  && (bus.i_retire_tag != '0)
                  && !w_full;
  assign bus.o_err = 1'b0;
`endif

  // Tag storage: reset preloads tags 1..NUM_TAGS, retire appends at wr_ptr.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= (i < NUM_TAGS) ? TAG_W'(i + 1) : '0;
    end else if (w_free_ok) begin
      r_mem[r_wr_ptr] <= bus.i_retire_tag;
    end
  end

  // Pointers: flush rolls rd_ptr back to just past the post-retire wr_ptr.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= TAG_W'(NUM_TAGS);
    end else begin
      r_wr_ptr <= w_wr_next;
      if (bus.i_flush)
        r_rd_ptr <= w_wr_next + 1'b1;
      else if (w_alloc_ok)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_rob_tag_free_list.sv
// Directed bench for rob_tag_free_list with a queue-based free-list model.
// Builds with or without ROB_TAG_FREE_CHECK_EN.
module tb_rob_tag_free_list;
  localparam int TAG_W = 6;
  localparam int NT    = 63;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rob_tag_free_list_if #(.TAG_W(TAG_W)) bus ();

  rob_tag_free_list #(
    .TAG_W(TAG_W),
    .NUM_TAGS(NT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int vec = 0;
  int bad = 0;

  // Model: fq = free tags in pop order, fl = in-flight tags in alloc order.
  int fq[$];
  int fl[$];
  int m_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    fl.delete();
    for (int t = 1; t <= NT; t++) fq.push_back(t);
    m_err = 0;
  endtask

  task automatic model_step();
    int  t;
    int  idx;
    bit  fr;
    bit  al;
    t   = int'(bus.i_retire_tag);
    idx = -1;
    foreach (fl[i]) if (fl[i] == t) idx = i;
    fr = bus.i_retire_valid && (t != 0) && (fq.size() < NT);
`ifdef ROB_TAG_FREE_CHECK_EN
    fr = fr && (idx >= 0);
    if (bus.i_retire_valid && !fr) m_err = 1;
`endif
    al = bus.i_alloc_req && (fq.size() > 0) && !bus.i_flush;
    if (al) fl.push_back(fq.pop_front());
    if (fr) begin
      if (idx >= 0) fl.delete(idx);
      fq.push_back(t);
    end
    if (bus.i_flush) begin
      fq = {fl, fq};
      fl.delete();
    end
  endtask

  task automatic step(input bit a, input bit rv, input int t, input bit f);
    bus.i_alloc_req    = a;
    bus.i_retire_valid = rv;
    bus.i_retire_tag   = TAG_W'(t);
    bus.i_flush        = f;
    @(posedge clk);
    model_step();
    #1;
    bus.i_alloc_req    = 1'b0;
    bus.i_retire_valid = 1'b0;
    bus.i_retire_tag   = '0;
    bus.i_flush        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("m_count", int'(bus.o_count), fq.size());
        chk("m_valid", int'(bus.o_alloc_valid), int'(fq.size() > 0));
        if (fq.size() > 0)
          chk("m_tag", int'(bus.o_alloc_tag), fq[0]);
        chk("m_err", int'(bus.o_err), m_err);
      end
    end
  end

  initial begin
    bus.i_alloc_req    = 1'b0;
    bus.i_retire_valid = 1'b0;
    bus.i_retire_tag   = '0;
    bus.i_flush        = 1'b0;
    model_reset();
    do_reset();

    chk("rst_count", int'(bus.o_count), 63);
    chk("rst_tag", int'(bus.o_alloc_tag), 1);
    chk("rst_valid", int'(bus.o_alloc_valid), 1);
    chk("rst_err", int'(bus.o_err), 0);

    for (int i = 0; i < 63; i++) begin
      chk("drain_tag", int'(bus.o_alloc_tag), i + 1);
      step(1, 0, 0, 0);
    end
    chk("empty_valid", int'(bus.o_alloc_valid), 0);
    chk("empty_count", int'(bus.o_count), 0);
    step(1, 0, 0, 0);
    chk("empty_pop_count", int'(bus.o_count), 0);
    step(0, 1, 1, 0);
    chk("empty_refill_cnt", int'(bus.o_count), 1);
    chk("empty_refill_tag", int'(bus.o_alloc_tag), 1);

    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 2, 0);
    chk("ret2_count", int'(bus.o_count), 60);
    for (int i = 6; i <= 63; i++) begin
      chk("ret2_tag", int'(bus.o_alloc_tag), i);
      step(1, 0, 0, 0);
    end
    chk("wrap_tag1", int'(bus.o_alloc_tag), 1);
    step(1, 0, 0, 0);
    chk("wrap_tag2", int'(bus.o_alloc_tag), 2);
    step(1, 0, 0, 0);
    chk("wrap_count", int'(bus.o_count), 0);

    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("same_pre_count", int'(bus.o_count), 58);
    chk("same_pre_tag", int'(bus.o_alloc_tag), 6);
    step(1, 1, 3, 0);
    chk("same_count", int'(bus.o_count), 58);
    for (int i = 0; i < 58; i++) begin
      chk("same_tag", int'(bus.o_alloc_tag), (i < 57) ? 7 + i : 3);
      step(1, 0, 0, 0);
    end

    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 2, 0);
    step(0, 1, 3, 0);
    step(1, 1, 4, 1);
    chk("flush_count", int'(bus.o_count), 63);
    chk("flush_tag", int'(bus.o_alloc_tag), 5);
    for (int i = 0; i < 63; i++) begin
      chk("flush_seq", int'(bus.o_alloc_tag), (i < 59) ? 5 + i : i - 58);
      step(1, 0, 0, 0);
    end

    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 1, 9, 0);
`ifdef ROB_TAG_FREE_CHECK_EN
    chk("bad9_count", int'(bus.o_count), 60);
    chk("bad9_err", int'(bus.o_err), 1);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    chk("bad9_sticky", int'(bus.o_err), 1);
    step(0, 1, 0, 0);
    chk("tag0_err", int'(bus.o_err), 1);
`else
    chk("bad9_count", int'(bus.o_count), 61);
    chk("bad9_err", int'(bus.o_err), 0);
`endif

    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_count", int'(bus.o_count), 63);
    chk("arst_tag", int'(bus.o_alloc_tag), 1);
    chk("arst_err", int'(bus.o_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 0, 0, 0);
    chk("post_rst_tag", int'(bus.o_alloc_tag), 2);
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/rob_tag_free_list.md
# rob_tag_free_list

Circular free list of reorder-buffer tags sitting directly upstream of the ROB. Dispatch pops a tag for every non-JUMP instruction it writes into the ROB. Retire pushes each tag back as the ROB head retires. On a taken-branch flush, every in-flight tag is reclaimed in a single cycle by rolling the read pointer back.

## Interface
Parameters:
- TAG_W, 6, tag width; matches the ROB FIFO/RF index width.
- NUM_TAGS, 2**TAG_W-1, managed tags 1..NUM_TAGS. Tag 0 is reserved as "no tag" because the retire bus drives rd_tag=0 when idle.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_alloc_req  in  1  dispatch pops a tag (dispatch_en && type!=JUMP)
- o_alloc_tag  out  TAG_W  tag at the head, valid whenever o_alloc_valid=1 (first-word fall-through)
- o_alloc_valid  out  1  list non-empty
- i_retire_valid  in  1  ROB retired its head this cycle
- i_retire_tag  in  TAG_W  tag being retired
- i_flush  in  1  retire-bus flush (taken branch at retire)
- o_count  out  TAG_W  number of free tags, 0..NUM_TAGS
- o_err  out  1  sticky illegal-free flag (see Configuration)

## Operation
- Storage: 2**TAG_W slots × TAG_W bits, plus rd_ptr and wr_ptr (TAG_W bits each, natural wrap); count = wr_ptr − rd_ptr mod 2**TAG_W.
- Reset state:
  - Slot i holds tag i+1 for i=0..NUM_TAGS−1; the last slot holds 0.
  - rd_ptr=0, wr_ptr=NUM_TAGS, so o_count=NUM_TAGS, o_alloc_valid=1, o_alloc_tag=1, o_err=0.
- Alloc: when i_alloc_req && o_alloc_valid && !i_flush, rd_ptr++.
  - i_alloc_req while empty is ignored; dispatch must stall on !o_alloc_valid.
- Free: when i_retire_valid && i_retire_tag!=0, mem[wr_ptr] := i_retire_tag, wr_ptr++.
  - Free while count==NUM_TAGS is ignored.
  - Tag 0 is never written.
- Simultaneous alloc and free: both apply; count is unchanged. A freed tag is not bypassed to o_alloc_tag in the same cycle.
- Flush:
  - Retire ordering equals allocation ordering, so the in-flight tags still sit in slots wr_ptr+1 .. rd_ptr−1.
  - On i_flush, the retire write (if any) is applied first, then rd_ptr := wr_ptr_next + 1, giving count=NUM_TAGS.
  - Alloc is suppressed in the flush cycle.
  - The branch's own tag, retired in the flush cycle, is included in the reclaimed tags.
- No FSM beyond pointer state. Behaviour is defined by the full/empty/flush priority: flush > free > alloc.

## Timing
- o_alloc_tag, o_alloc_valid and o_count are combinational from registered state (mem, pointers).
- Popped tag: the tag presented in cycle N is consumed at edge N; the next tag appears at N+1.
- Freed tag: allocatable from cycle N+1 after the free edge; earliest reuse is one cycle after retire.
- Flush: reclamation takes effect at the edge of the flush cycle; o_count=NUM_TAGS from the next cycle.
- i_rst asserted mid-operation: all state returns immediately (asynchronously) to the reset values listed under Operation; o_err clears.

## Configuration
- ROB_TAG_FREE_CHECK_EN
  - Defined:
    - Keep a NUM_TAGS-bit in-flight bitmap: set on alloc, clear on free, all cleared on flush.
    - A free of tag 0 with i_retire_valid, a free of a tag not in flight, or a free while full is dropped and sets o_err, which stays set until i_rst.
  - Undefined:
    - No bitmap.
    - o_err is tied to 0.
    - Illegal frees of a non-zero tag when not full are written unchecked.

## Test plan
- Reset -> o_count=63, o_alloc_tag=1, o_alloc_valid=1, o_err=0.
- 63 consecutive allocs -> tags 1..63 in order; then o_alloc_valid=0 and o_count=0; a 64th i_alloc_req leaves the pointers unchanged.
- Alloc 1..5, retire 1 and 2 -> o_count=60; after allocating 6..63, the next tags are 1 then 2.
- Same-cycle alloc (tag 6) and retire (tag 3) with count=58 -> count stays 58; tag 3 is returned after the remaining free tags.
- Alloc 1..10, retire 1..3, then flush with retire tag 4 in the same cycle -> o_count=63 next cycle, o_alloc_tag=5, followed by 6..63, 1..4.
- ROB_TAG_FREE_CHECK_EN defined: retire tag 9 while tag 9 is not in flight -> write dropped, o_count unchanged, o_err=1 until i_rst.
